// File: rtl/alu_op_decode_stage.sv
// RV32I decode stage: turns a fetched instruction into the AluOp,
// operand selects, immediate and register fields consumed by execute.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    instr/pc handshake from fetch
//   instr, pc            raw instruction word and its address
//   flush                kill the held and the incoming instruction
//   out_valid/out_ready  decoded bundle handshake toward execute
//   alu_op, a_sel, b_sel ALU operation and operand sources
//   imm                  sign-extended immediate
//   rd, rs1, rs2         register fields
//   reg_write            instruction writes rd
//   pc_out               pc of the held instruction
//   illegal              undecodable encoding
//
// Optional feature: define DECODE_ILLEGAL_CHECK_EN to flag illegal
// encodings; otherwise illegal is tied 0.

module alu_op_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_op,
    output logic [1:0]      a_sel,
    output logic            b_sel,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            reg_write,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic            w_is_op, w_is_opimm, w_is_ldjr, w_is_store;
    logic            w_is_br, w_is_lui, w_is_auipc, w_is_jal;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [3:0]      w_alu;
    logic [1:0]      w_a;
    logic            w_b;
    logic [XLEN-1:0] w_imm;
    logic            w_rw;
    logic            w_ill;
    logic            w_load;

    logic            r_valid;
    logic [3:0]      r_alu_op;
    logic [1:0]      r_a_sel;
    logic            r_b_sel;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rd, r_rs1, r_rs2;
    logic            r_reg_write;
    logic [XLEN-1:0] r_pc;
    logic            r_illegal;

    assign w_opc = instr[6:0];
    assign w_f3  = instr[14:12];
    assign w_f7  = instr[31:25];

    assign w_is_op    = (w_opc == OPC_OP);
    assign w_is_opimm = (w_opc == OPC_OPIMM);
    assign w_is_ldjr  = (w_opc == OPC_LOAD) || (w_opc == OPC_JALR);
    assign w_is_store = (w_opc == OPC_STORE);
    assign w_is_br    = (w_opc == OPC_BRANCH);
    assign w_is_lui   = (w_opc == OPC_LUI);
    assign w_is_auipc = (w_opc == OPC_AUIPC);
    assign w_is_jal   = (w_opc == OPC_JAL);

    assign w_imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign w_imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u = {instr[31:12], 12'b0};
    assign w_imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                      instr[20], instr[30:21], 1'b0};

    always_comb begin
        w_alu = ALU_ADD;
        w_a   = 2'b00;
        w_b   = 1'b0;
        w_imm = '0;
        w_rw  = 1'b0;
        unique case (1'b1)
            w_is_op: begin
                w_alu = {w_f7[5], w_f3};
                w_rw  = 1'b1;
            end
            w_is_opimm: begin
                // funct7[5] only selects SRAI; shifts take a 5-bit shamt
                w_alu = {(w_f3 == 3'b101) & w_f7[5], w_f3};
                w_b   = 1'b1;
                w_rw  = 1'b1;
                if (w_f3 == 3'b001 || w_f3 == 3'b101)
                    w_imm = {{(XLEN-5){1'b0}}, instr[24:20]};
                else
                    w_imm = w_imm_i;
            end
            w_is_ldjr: begin
                w_b   = 1'b1;
                w_imm = w_imm_i;
                w_rw  = 1'b1;
            end
            w_is_store: begin
                w_b   = 1'b1;
                w_imm = w_imm_s;
            end
            w_is_br: begin
                w_imm = w_imm_b;
                case (w_f3[2:1])
                    2'b00:   w_alu = ALU_SUB;
                    2'b10:   w_alu = ALU_SLT;
                    2'b11:   w_alu = ALU_SLTU;
                    default: w_alu = ALU_ADD;
                endcase
            end
            w_is_lui: begin
                w_a   = 2'b10;
                w_b   = 1'b1;
                w_imm = w_imm_u;
                w_rw  = 1'b1;
            end
            w_is_auipc: begin
                w_a   = 2'b01;
                w_b   = 1'b1;
                w_imm = w_imm_u;
                w_rw  = 1'b1;
            end
            w_is_jal: begin
                w_a   = 2'b01;
                w_b   = 1'b1;
                w_imm = w_imm_j;
                w_rw  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic w_known;
    logic w_f7_ok;

    assign w_known = w_is_op | w_is_opimm | w_is_ldjr | w_is_store |
                     w_is_br | w_is_lui | w_is_auipc | w_is_jal;
    assign w_f7_ok = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);

    assign w_ill = !w_known
        || (instr[1:0] != 2'b11)
        || (w_is_op && !w_f7_ok)
        || (w_is_op && w_f7 == 7'b0100000
            && w_f3 != 3'b000 && w_f3 != 3'b101)
        || (w_is_opimm && w_f3 == 3'b001 && w_f7 != 7'b0)
        || (w_is_opimm && w_f3 == 3'b101 && !w_f7_ok);
`else
    assign w_ill = 1'b0;
`endif

    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_alu_op    <= '0;
            r_a_sel     <= '0;
            r_b_sel     <= 1'b0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_reg_write <= 1'b0;
            r_pc        <= '0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid     <= 1'b1;
            r_alu_op    <= w_ill ? ALU_ADD : w_alu;
            r_a_sel     <= w_a;
            r_b_sel     <= w_b;
            r_imm       <= w_imm;
            r_rd        <= instr[11:7];
            r_rs1       <= instr[19:15];
            r_rs2       <= instr[24:20];
            r_reg_write <= w_rw & ~w_ill;
            r_pc        <= pc;
            r_illegal   <= w_ill;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign alu_op    = r_alu_op;
    assign a_sel     = r_a_sel;
    assign b_sel     = r_b_sel;
    assign imm       = r_imm;
    assign rd        = r_rd;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign reg_write = r_reg_write;
    assign pc_out    = r_pc;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_op_decode_stage.sv
// Scoreboard bench for alu_op_decode_stage: directed RV32I words with
// hand-decoded expectations, plus stall, flush and async reset checks.

module tb_alu_op_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  alu;
        logic [1:0]  a;
        logic        b;
        logic [31:0] imm;
        logic        ichk;
        logic        cchk;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rw;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic        reg_write;
    logic [31:0] pc_out;
    logic        illegal;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t sbq[$];
    vec_t mon_e;
    vec_t tbl[$];
    int   tries;

    always #5 clk = ~clk;

    alu_op_decode_stage #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .imm       (imm),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .reg_write (reg_write),
        .pc_out    (pc_out),
        .illegal   (illegal)
    );

    function automatic vec_t mk(
        input logic [31:0] i_instr, input logic [31:0] i_pc,
        input logic [3:0] i_alu, input logic [1:0] i_a, input logic i_b,
        input logic [31:0] i_imm, input logic i_ichk, input logic i_cchk,
        input logic [4:0] i_rd, input logic [4:0] i_rs1,
        input logic [4:0] i_rs2, input logic i_rw, input logic i_ill);
        vec_t v;
        v.instr = i_instr; v.pc = i_pc; v.alu = i_alu; v.a = i_a;
        v.b = i_b; v.imm = i_imm; v.ichk = i_ichk; v.cchk = i_cchk;
        v.rd = i_rd; v.rs1 = i_rs1; v.rs2 = i_rs2; v.rw = i_rw;
        v.ill = i_ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v, output int n);
        bit acc;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        instr = v.instr;
        pc = v.pc;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            n++;
            if (acc && !flush) sbq.push_back(v);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send timeout pc %h", v.pc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL monitor: unexpected bundle pc_out %h", pc_out);
            end else begin
                mon_e = sbq.pop_front();
                if (alu_op !== mon_e.alu || rd !== mon_e.rd ||
                    rs1 !== mon_e.rs1 || rs2 !== mon_e.rs2 ||
                    reg_write !== mon_e.rw || illegal !== mon_e.ill ||
                    pc_out !== mon_e.pc ||
                    (mon_e.ichk && imm !== mon_e.imm) ||
                    (mon_e.cchk && (a_sel !== mon_e.a ||
                                    b_sel !== mon_e.b))) begin
                    n_err++;
                    $display("FAIL bundle pc %h: got alu %b a %b b %b imm %h rd %0d rs1 %0d rs2 %0d rw %b ill %b pc %h expected alu %b a %b b %b imm %h rd %0d rs1 %0d rs2 %0d rw %b ill %b",
                        mon_e.pc, alu_op, a_sel, b_sel, imm, rd, rs1, rs2,
                        reg_write, illegal, pc_out, mon_e.alu, mon_e.a,
                        mon_e.b, mon_e.imm, mon_e.rd, mon_e.rs1, mon_e.rs2,
                        mon_e.rw, mon_e.ill);
                end
            end
        end
    end

    initial begin
        vec_t va, vb, vc;
        logic ill_on;
`ifdef DECODE_ILLEGAL_CHECK_EN
        ill_on = 1'b1;
`else
        ill_on = 1'b0;
`endif
        tbl.push_back(mk(32'h002081B3, 32'h100, 4'b0000, 2'b00, 1'b0, 32'h0,        1'b0, 1'b1, 5'd3,  5'd1, 5'd2,  1'b1, 1'b0));
        tbl.push_back(mk(32'h402081B3, 32'h104, 4'b1000, 2'b00, 1'b0, 32'h0,        1'b0, 1'b1, 5'd3,  5'd1, 5'd2,  1'b1, 1'b0));
        tbl.push_back(mk(32'h40335293, 32'h108, 4'b1101, 2'b00, 1'b1, 32'h3,        1'b1, 1'b1, 5'd5,  5'd6, 5'd3,  1'b1, 1'b0));
        tbl.push_back(mk(32'h123450B7, 32'h10C, 4'b0000, 2'b10, 1'b1, 32'h12345000, 1'b1, 1'b1, 5'd1,  5'd8, 5'd3,  1'b1, 1'b0));
        tbl.push_back(mk(32'hFFF00093, 32'h110, 4'b0000, 2'b00, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd1,  5'd0, 5'd31, 1'b1, 1'b0));
        tbl.push_back(mk(32'h0020A423, 32'h114, 4'b0000, 2'b00, 1'b1, 32'h8,        1'b1, 1'b1, 5'd8,  5'd1, 5'd2,  1'b0, 1'b0));
        tbl.push_back(mk(32'hFE208EE3, 32'h118, 4'b1000, 2'b00, 1'b0, 32'hFFFFFFFC, 1'b1, 1'b1, 5'd29, 5'd1, 5'd2,  1'b0, 1'b0));
        tbl.push_back(mk(32'h0020E463, 32'h11C, 4'b0011, 2'b00, 1'b0, 32'h8,        1'b1, 1'b1, 5'd8,  5'd1, 5'd2,  1'b0, 1'b0));
        tbl.push_back(mk(32'h010000EF, 32'h120, 4'b0000, 2'b01, 1'b1, 32'h10,       1'b1, 1'b1, 5'd1,  5'd0, 5'd16, 1'b1, 1'b0));
        tbl.push_back(mk(32'h00001117, 32'h124, 4'b0000, 2'b01, 1'b1, 32'h1000,     1'b1, 1'b1, 5'd2,  5'd0, 5'd0,  1'b1, 1'b0));
        tbl.push_back(mk(32'h0062A233, 32'h128, 4'b0010, 2'b00, 1'b0, 32'h0,        1'b0, 1'b1, 5'd4,  5'd5, 5'd6,  1'b1, 1'b0));
        tbl.push_back(mk(32'h00335293, 32'h12C, 4'b0101, 2'b00, 1'b1, 32'h3,        1'b1, 1'b1, 5'd5,  5'd6, 5'd3,  1'b1, 1'b0));
        tbl.push_back(mk(32'h402091B3, 32'h130, ill_on ? 4'b0000 : 4'b1001,
                         2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2,
                         !ill_on, ill_on));
        tbl.push_back(mk(32'h00000000, 32'h134, 4'b0000, 2'b00, 1'b0, 32'h0,
                         1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, ill_on));

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0;
        #12;
        chk("reset out_valid", out_valid, 0);
        chk("reset alu_op", alu_op, 0);
        chk("reset illegal", illegal, 0);
        chk("reset in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        foreach (tbl[i]) begin
            send(tbl[i], tries);
            if (i == 1 || i == 2) chk("b2b in_ready", tries, 1);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain out_valid", out_valid, 0);

        // stall: A held while B waits
        va = tbl[1]; va.pc = 32'h200;
        vb = tbl[2]; vb.pc = 32'h204;
        out_ready = 1'b0;
        send(va, tries);
        in_valid = 1'b1; instr = vb.instr; pc = vb.pc;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall in_ready", in_ready, 0);
            chk("stall out_valid", out_valid, 1);
            chk("stall alu_op", alu_op, 4'b1000);
            chk("stall pc_out", pc_out, 32'h200);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(vb, tries);
        chk("release first try", tries, 1);
        chk("release pc_out", pc_out, 32'h204);
        @(negedge clk);
        @(posedge clk);
        #1;

        // flush while stalled with a pending word
        vc = tbl[3]; vc.pc = 32'h300;
        out_ready = 1'b0;
        send(vc, tries);
        in_valid = 1'b1; instr = tbl[0].instr; pc = 32'h304; flush = 1'b1;
        @(negedge clk);
        chk("flush stall in_ready", in_ready, 0);
        if (sbq.size() != 0) void'(sbq.pop_front());
        @(posedge clk);
        #1;
        chk("flush kills held", out_valid, 0);
        out_ready = 1'b1;
        pc = 32'h308;
        @(posedge clk);
        #1;
        chk("flush drops accepted", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("flush idle", out_valid, 0);

        // async reset mid-bundle
        va = tbl[2]; va.pc = 32'h400;
        out_ready = 1'b0;
        send(va, tries);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst alu_op", alu_op, 0);
        chk("async rst pc_out", pc_out, 0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        vb = tbl[3]; vb.pc = 32'h500;
        send(vb, tries);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_op_decode_stage.md
Name: alu_op_decode_stage

Overview:
- Registered RV32I decode stage that produces the 4-bit AluOp and operand controls that the ALU consumes.
- Accepts a fetched instruction and PC over a valid/ready handshake.
- Decodes opcode/funct3/funct7 into AluOp, operand selects, the immediate and register fields.
- Presents the result from one pipeline register toward execute, with stall and flush support.

Parameters:
- XLEN, 32, datapath width of pc, pc_out and imm (only 32 supported).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  instr/pc valid from fetch.
- in_ready  output  1  stage can accept this cycle.
- instr  input  32  raw instruction word.
- pc  input  XLEN  instruction address.
- flush  input  1  kill held and incoming instruction.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute accepts the bundle.
- alu_op  output  4  ALU operation code.
- a_sel  output  2  ALU A source: 00 = rs1, 01 = pc, 10 = zero.
- b_sel  output  1  ALU B source: 0 = rs2, 1 = imm.
- imm  output  XLEN  sign-extended immediate.
- rd, rs1, rs2  output  5 each  register fields (instr[11:7], [19:15], [24:20]).
- reg_write  output  1  instruction writes rd.
- pc_out  output  XLEN  pc of the held instruction.
- illegal  output  1  undecodable encoding.

Behaviour:
- Reset (async, immediate): out_valid = 0; all bundle registers = 0, so alu_op = 0000 and illegal = 0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Load on in_valid && in_ready.
  - Latency is 1 cycle: the bundle appears the edge after acceptance.
  - While out_valid && !out_ready, every output holds stable and in_ready = 0.
  - out_valid drops after consumption if nothing new is loaded.
  - Back-to-back throughput is 1 instruction/cycle.
- Flush has priority over load: the next edge sets out_valid = 0 and discards any incoming word; other fields may hold stale values.
- Reset mid-stall or mid-flush returns to the reset state at once.
- AluOp encoding (fixed):
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011.
  - XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Decode by opcode:
  - OP 0110011: alu_op = {funct7[5], funct3}; a_sel 00, b_sel 0, reg_write 1.
  - OP-IMM 0010011: alu_op = {(funct3==101) & funct7[5], funct3}; b_sel 1; I-imm, with shamt = instr[24:20] zero-extended for shifts; reg_write 1.
  - LOAD 0000011 / JALR 1100111: ADD, b_sel 1, I-imm, reg_write 1.
  - STORE 0100011: ADD, b_sel 1, S-imm, reg_write 0.
  - BRANCH 1100011: BEQ/BNE → SUB; BLT/BGE → SLT; BLTU/BGEU → SLTU. b_sel 0, B-imm, reg_write 0.
  - LUI 0110111: ADD, a_sel 10, b_sel 1, U-imm (instr[31:12] << 12), reg_write 1.
  - AUIPC 0010111: ADD, a_sel 01, b_sel 1, U-imm, reg_write 1.
  - JAL 1101111: ADD, a_sel 01, b_sel 1, J-imm, reg_write 1.
- Immediates are sign-extended from instr[31]; the B and J immediates have bit 0 = 0.
- rd = x0 still reports reg_write = 1; suppressing the write is the register file's job.

Optional Feature:
- Macro: DECODE_ILLEGAL_CHECK_EN.
- Defined, illegal = 1 for any of:
  - unknown opcode;
  - OP with funct7 other than 0000000/0100000;
  - OP with funct7 0100000 on funct3 other than 000/101;
  - OP-IMM SLLI with funct7 != 0;
  - OP-IMM SRLI/SRAI with funct7 other than 0000000/0100000;
  - instr[1:0] != 11.
- When illegal: reg_write forced 0 and alu_op forced 0000; the bundle still handshakes normally.
- Not defined: illegal tied 0, and unknown opcodes decode as ADD with reg_write 0.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3), pc 0x100, out_ready 1 → next edge: out_valid 1, alu_op 0000, b_sel 0, rd 3, rs1 1, rs2 2, reg_write 1, pc_out 0x100.
- SUB (0x402081B3) then SRAI x5,x6,3 (0x40335293) back-to-back → alu_op 1000, then 1101 with b_sel 1, imm 0x00000003, rd 5; in_ready stays 1.
- LUI x1,0x12345 (0x123450B7) → a_sel 10, b_sel 1, imm 0x12345000, alu_op 0000.
- Stall: hold out_ready 0 for 3 cycles with in_valid 1 → bundle unchanged, in_ready 0; release → next word loads on the following edge.
- Flush during stall with a pending input → out_valid 0 after one edge, incoming word dropped; assert rst asynchronously mid-bundle → out_valid 0 immediately, without waiting for a clock edge.
- With DECODE_ILLEGAL_CHECK_EN, 0x402091B3 → illegal 1, reg_write 0, alu_op 0000; without the macro → illegal 0.
